// File: rtl/mux_pipe_stage_if.sv
// mux_pipe_stage_if: the handshake and data bundle of mux_pipe_stage.
// The upstream word/select side and the downstream result side are grouped
// together. The master modport is used by whatever drives the stage, and the
// slave modport is used by the stage itself.
// When MUX_SEL_ERR_EN is defined, the bundle also carries sel_err.
//
// Handshake: a word moves on a rising clk edge when valid && ready on that
// side (in_valid/in_ready upstream, out_valid/out_ready downstream). A
// producer holds its word and its select stable until the transfer happens.
// ready never depends combinationally on valid of the same side.
interface mux_pipe_stage_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   d;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out;
  logic [SELW-1:0]      out_sel;
`ifdef MUX_SEL_ERR_EN
  logic                 sel_err;

  modport master (
    output in_valid, sel, d, out_ready,
    input  in_ready, out_valid, out, out_sel, sel_err
  );

  modport slave (
    input  in_valid, sel, d, out_ready,
    output in_ready, out_valid, out, out_sel, sel_err
  );
`else
  modport master (
    output in_valid, sel, d, out_ready,
    input  in_ready, out_valid, out, out_sel
  );

  modport slave (
    input  in_valid, sel, d, out_ready,
    output in_ready, out_valid, out, out_sel
  );
`endif
endinterface

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: a registered N-to-1 word multiplexer with a two-entry
// elastic buffer. The two entries are a main register and a skid register.
// Upstream selects one of N packed channels, and the selected word is
// registered together with its select value.
// in_ready is decoded from registered occupancy and reset only, so there is
// no combinational path from out_ready to in_ready. Throughput is still one
// word per cycle.
// A select of N or above resolves to an all-zero word.
// Optional feature, macro MUX_SEL_ERR_EN: a per-entry sel_err flag marks
// words whose select was out of range, and an assertion flags such accepts.
module mux_pipe_stage #(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input  logic                clk,
  input  logic                reset,
  mux_pipe_stage_if.slave     bus,
  output logic [1:0]          dbg_state
);
  localparam int SELW = $clog2(N);

  // Occupancy: EMPTY = nothing held, ONE = main only, FULL = main + skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  main_data;
  logic [WIDTH-1:0]  skid_data;
  logic [SELW-1:0]   main_sel;
  logic [SELW-1:0]   skid_sel;
  logic [WIDTH-1:0]  new_data;
  logic              acc;
  logic              pop;

`ifdef MUX_SEL_ERR_EN
  logic              main_err;
  logic              skid_err;
  logic              new_err;

  assign new_err = (int'(bus.sel) >= N);
`endif

  // Channel selection; unmatched (out-of-range) selects leave the word at zero
  always_comb begin
    new_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(bus.sel) == k) begin
        new_data = bus.d[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.in_ready  = !reset && (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out       = main_data;
  assign bus.out_sel   = main_sel;
  assign acc           = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign dbg_state     = state;

`ifdef MUX_SEL_ERR_EN
  assign bus.sel_err   = main_err && bus.out_valid;
`endif

  // Occupancy FSM with main/skid storage; the skid only fills while main is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
`ifdef MUX_SEL_ERR_EN
      main_err  <= 1'b0;
      skid_err  <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_data <= new_data;
            main_sel  <= bus.sel;
`ifdef MUX_SEL_ERR_EN
            main_err  <= new_err;
`endif
            state     <= ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_data <= new_data;
            main_sel  <= bus.sel;
`ifdef MUX_SEL_ERR_EN
            main_err  <= new_err;
`endif
          end else if (acc) begin
            skid_data <= new_data;
            skid_sel  <= bus.sel;
`ifdef MUX_SEL_ERR_EN
            skid_err  <= new_err;
`endif
            state     <= FULL;
          end else if (pop) begin
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            skid_data <= '0;
            skid_sel  <= '0;
`ifdef MUX_SEL_ERR_EN
            main_err  <= skid_err;
            skid_err  <= 1'b0;
`endif
            state     <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef MUX_SEL_ERR_EN
  // An accepted out-of-range select is a sign of an upstream decode bug
  a_sel_in_range: assert property (@(posedge clk) disable iff (reset) acc |-> !new_err);
`endif

endmodule
